// File: rtl/risk_pkg.sv
// Shared geometry, address helpers and FSM encoding for the RISK strided tile load/store unit.
// The tile/bank geometry is fixed here; every RTL file takes its widths from this package.
package risk_pkg;

    localparam int unsigned SZ        = 4;
    localparam int unsigned BITS      = 18;
    localparam int unsigned LOGCNT    = 5;
    localparam int unsigned DEPTH_LOG = 10;
    localparam int unsigned N         = SZ * SZ;
    localparam int unsigned AW        = DEPTH_LOG + LOGCNT;
    localparam int unsigned PW        = $clog2(N + 1);
    localparam int unsigned NBANK     = 1 << LOGCNT;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StIssue,
        StDrain,
        StResp
    } state_e;

    function automatic logic [LOGCNT-1:0] elem_bank(input logic [AW-1:0] addr);
        return addr[LOGCNT-1:0];
    endfunction

    function automatic logic [DEPTH_LOG-1:0] elem_row(input logic [AW-1:0] addr);
        return addr[AW-1:LOGCNT];
    endfunction

endpackage

// File: rtl/risk_bank.sv
// Single-port BRAM bank: one read or one write per cycle, read data registered (1-cycle latency).
module risk_bank
    import risk_pkg::*;
(
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] row,
    input  logic [BITS-1:0]      wdata,
    output logic [BITS-1:0]      rdata
);

    logic [BITS-1:0] mem [2**DEPTH_LOG];

    // No reset: maps onto block RAM, contents survive resetn.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[row] <= wdata;
            end else begin
                rdata <= mem[row];
            end
        end
    end

endmodule

// File: rtl/risk_mem_strided.sv
// Banked strided gather/scatter of an SZ x SZ tile; bank conflicts are serialised over extra
// passes, each bank servicing its lowest-indexed pending element per pass.
module risk_mem_strided
    import risk_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [AW-1:0]     req_stride_x,
    input  logic [AW-1:0]     req_stride_y,
    input  logic [BITS*N-1:0] req_dat_w,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [BITS*N-1:0] resp_dat_r,
    output logic [PW-1:0]     resp_passes
);

    state_e                     state_q, state_d;
    logic                       we_q;
    logic [AW-1:0]              base_q, sx_q, sy_q;
    logic [N-1:0][BITS-1:0]     wdat_q, lane_q;
    logic [N-1:0][AW-1:0]       addr_q, addr_d;
    logic [N-1:0]               pend_q, picked, pend_left;
    logic [NBANK-1:0][N-1:0]    pick, sel_q;
    logic [NBANK-1:0][BITS-1:0] bank_rdata;
    logic [N-1:0]               cap_mask;
    logic [N-1:0][BITS-1:0]     cap_data;
    logic [PW-1:0]              passes_q;
    logic                       resp_valid_q;
    logic                       accept, issue;

    // Element k sits at (x, y) = (k % SZ, k / SZ); constant multipliers reduce to shift-add.
    for (genvar k = 0; k < N; k++) begin : g_addr
        localparam logic [AW-1:0] X = AW'(k % SZ);
        localparam logic [AW-1:0] Y = AW'(k / SZ);
        assign addr_d[k] = base_q + sx_q * X + sy_q * Y;
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [N-1:0]           match;
        logic [DEPTH_LOG-1:0]   row;
        logic [BITS-1:0]        wdata;

        always_comb begin
            match = '0;
            for (int k = 0; k < N; k++) begin
                match[k] = pend_q[k] && (elem_bank(addr_q[k]) == LOGCNT'(b));
            end
        end

        // Isolate the lowest set bit: lowest index wins, so duplicate writes land in k order.
        assign pick[b] = issue ? (match & (~match + N'(1))) : '0;

        always_comb begin
            row   = '0;
            wdata = '0;
            for (int k = 0; k < N; k++) begin
                if (pick[b][k]) begin
                    row   = row | elem_row(addr_q[k]);
                    wdata = wdata | wdat_q[k];
                end
            end
        end

        risk_bank u_bank (
            .clk   (clk),
            .en    (|pick[b]),
            .we    (we_q),
            .row   (row),
            .wdata (wdata),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        picked = '0;
        for (int b = 0; b < NBANK; b++) begin
            picked = picked | pick[b];
        end
        pend_left = pend_q & ~picked;
    end

    // Read data of the previous pass, steered to lanes by that pass's one-hot masks.
    always_comb begin
        cap_mask = '0;
        cap_data = '0;
        for (int b = 0; b < NBANK; b++) begin
            for (int k = 0; k < N; k++) begin
                if (sel_q[b][k]) begin
                    cap_mask[k] = 1'b1;
                    cap_data[k] = cap_data[k] | bank_rdata[b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StAddr;
            StAddr:  state_d = StIssue;
            StIssue: if (pend_left == '0) state_d = StDrain;
            StDrain: state_d = StResp;
            StResp:  if (resp_valid_q && resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = resetn && (state_q == StIdle);
        accept    = req_valid && req_ready;
        issue     = (state_q == StIssue);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_q         <= 1'b0;
            base_q       <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            wdat_q       <= '0;
            lane_q       <= '0;
            addr_q       <= '0;
            pend_q       <= '0;
            sel_q        <= '0;
            passes_q     <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                base_q   <= req_addr;
                sx_q     <= req_stride_x;
                sy_q     <= req_stride_y;
                wdat_q   <= req_dat_w;
                lane_q   <= '0;
                passes_q <= '0;
            end
            if (state_q == StAddr) begin
                addr_q <= addr_d;
                pend_q <= '1;
            end
            if (issue) begin
                pend_q   <= pend_left;
                passes_q <= passes_q + PW'(1);
            end
            sel_q <= we_q ? '0 : pick;
            for (int k = 0; k < N; k++) begin
                if (cap_mask[k]) lane_q[k] <= cap_data[k];
            end
            // Response valid comes from a flop, one cycle into RESP.
            resp_valid_q <= (state_q == StResp) && !(resp_valid_q && resp_ready);
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_dat_r  = lane_q;
    assign resp_passes = passes_q;

endmodule

// File: tb/tb_risk_mem_strided.sv
// Scoreboard bench for risk_mem_strided: an element-level memory model predicts data, passes and
// response latency at drive time; a negedge monitor compares them when the response handshakes.
module tb_risk_mem_strided;
    import risk_pkg::*;

    localparam int W    = BITS * N;
    localparam int MASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr, req_stride_x, req_stride_y;
    logic [W-1:0]  req_dat_w;
    logic          resp_valid, resp_ready;
    logic [W-1:0]  resp_dat_r;
    logic [PW-1:0] resp_passes;

    always #5 clk = ~clk;

    risk_mem_strided dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_stride_x (req_stride_x),
        .req_stride_y (req_stride_y),
        .req_dat_w    (req_dat_w),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_dat_r   (resp_dat_r),
        .resp_passes  (resp_passes)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] dat;
        int           passes;
        int           lat;
    } exp_t;

    exp_t            sb[$];
    int              n_tests  = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              acc_cyc  = 0;
    int              done_cnt = 0;
    bit              seen_valid = 1'b0;
    logic [BITS-1:0] model [0:(1<<AW)-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: latency at first resp_valid, data/passes at the handshake.
    always @(negedge clk) begin
        if (!resetn) begin
            seen_valid <= 1'b0;
        end else if (resp_valid) begin
            if (sb.size() == 0) begin
                check("sb_empty", W'(sb.size()), W'(1));
            end else begin
                if (!seen_valid) check({sb[0].tag, "_lat"}, W'(cyc - acc_cyc), W'(sb[0].lat));
                seen_valid <= 1'b1;
                if (resp_ready) begin
                    check({sb[0].tag, "_dat"}, resp_dat_r, sb[0].dat);
                    check({sb[0].tag, "_passes"}, W'(resp_passes), W'(sb[0].passes));
                    void'(sb.pop_front());
                    seen_valid <= 1'b0;
                    done_cnt   <= done_cnt + 1;
                end
            end
        end
    end

    function automatic logic [W-1:0] mk_lanes(input int base);
        logic [W-1:0] r = '0;
        for (int k = 0; k < N; k++) r[k*BITS +: BITS] = BITS'(base + k);
        return r;
    endfunction

    task automatic drive_and_accept(input string tag, input logic we, input int addr,
                                    input int sx, input int sy, input logic [W-1:0] wdat);
        @(posedge clk); #1;
        req_we       = we;
        req_addr     = AW'(addr);
        req_stride_x = AW'(sx);
        req_stride_y = AW'(sy);
        req_dat_w    = wdat;
        req_valid    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (!req_ready) check({tag, "_accept"}, W'(req_ready), W'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic issue_req(input string tag, input logic we, input int addr,
                             input int sx, input int sy, input logic [W-1:0] wdat);
        exp_t         e;
        int           cnt[NBANK];
        int           a;
        int           p = 0;
        logic [W-1:0] ed = '0;
        foreach (cnt[i]) cnt[i] = 0;
        for (int k = 0; k < N; k++) begin
            a = (addr + sx * (k % SZ) + sy * (k / SZ)) & MASK;
            cnt[a % NBANK]++;
            if (we) model[a] = wdat[k*BITS +: BITS];
            else    ed[k*BITS +: BITS] = model[a];
        end
        foreach (cnt[i]) if (cnt[i] > p) p = cnt[i];
        e = '{tag, ed, p, p + 3};
        sb.push_back(e);
        drive_and_accept(tag, we, addr, sx, sy, wdat);
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 200 && done_cnt < target; i++) @(negedge clk);
        if (done_cnt < target) check({tag, "_timeout"}, W'(done_cnt), W'(target));
    endtask

    task automatic run_req(input string tag, input logic we, input int addr,
                           input int sx, input int sy, input logic [W-1:0] wdat);
        int target = done_cnt + 1;
        issue_req(tag, we, addr, sx, sy, wdat);
        wait_done(tag, target);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int target;
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_stride_x = '0;
        req_stride_y = '0;
        req_dat_w    = '0;
        resp_ready   = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", W'(req_ready), W'(0));
        check("rst_resp_valid", W'(resp_valid), W'(0));
        check("rst_resp_dat", resp_dat_r, W'(0));
        check("rst_resp_passes", W'(resp_passes), W'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("idle_req_ready", W'(req_ready), W'(1));

        // Conflict-free tile.
        run_req("t1_wr", 1'b1, 0, 1, 4, mk_lanes(100));
        run_req("t1_rd", 1'b0, 0, 1, 4, '0);

        // Reset mid-ISSUE of a 16-pass read.
        drive_and_accept("t6_rd", 1'b0, 0, 0, 0, '0);
        repeat (4) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("t6_rst_resp_valid", W'(resp_valid), W'(0));
        check("t6_rst_resp_dat", resp_dat_r, W'(0));
        check("t6_rst_resp_passes", W'(resp_passes), W'(0));
        check("t6_rst_req_ready", W'(req_ready), W'(0));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("t6_req_ready", W'(req_ready), W'(1));
        run_req("t6_rd2", 1'b0, 0, 1, 4, '0);

        // Every element in bank 0.
        run_req("t2_wr", 1'b1, 0, 32, 128, mk_lanes(500));
        run_req("t2_rd", 1'b0, 0, 32, 128, '0);

        // All lanes on one address: last write wins, every read lane gets it.
        run_req("t3_wr", 1'b1, 7, 0, 0, mk_lanes(0));
        run_req("t3_rd", 1'b0, 7, 0, 0, '0);

        // Address wrap-around at the top of the space.
        run_req("t4_wr", 1'b1, (1 << AW) - 2, 1, 4, mk_lanes(1000));
        run_req("t4_rd", 1'b0, (1 << AW) - 2, 1, 4, '0);

        // Response backpressure.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        target = done_cnt + 1;
        issue_req("t5_rd", 1'b0, 0, 1, 4, '0);
        for (int i = 0; i < 50 && !resp_valid; i++) @(negedge clk);
        check("t5_valid_seen", W'(resp_valid), W'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", W'(resp_valid), W'(1));
            check("t5_hold_dat", resp_dat_r, sb[0].dat);
            check("t5_hold_req_ready", W'(req_ready), W'(0));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_idle_req_ready", W'(req_ready), W'(1));
        check("t5_idle_resp_valid", W'(resp_valid), W'(0));
        wait_done("t5_rd", target);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
